// File: rtl/mw_fifo_pkg.sv
// Shared types and defaults for the multi-way FIFO and its prefix counter.
package mw_fifo_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_NUM_WAY = 3;
  localparam int MAX_WAY     = 8;

  // Wide enough to hold any lane count from 0 to MAX_WAY.
  typedef logic [3:0] lane_cnt_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mw_prefix_cnt.sv
// Counts the unbroken run of set bits from bit 0 and flags any set bit above a cleared one.
module mw_prefix_cnt
  import mw_fifo_pkg::*;
#(
  parameter int N = DEF_NUM_WAY
) (
  input  logic [N-1:0] vec_i,
  output lane_cnt_t    cnt_o,
  output logic         gap_o
);

  logic run;

  always_comb begin
    cnt_o = '0;
    gap_o = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        if (run) cnt_o = cnt_o + lane_cnt_t'(1);
        else     gap_o = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mw_fifo.sv
// Multi-lane show-ahead FIFO: up to NUM_WAY pushes and pops per cycle, prefix-only lane acceptance.
module mw_fifo
  import mw_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_WAY   = DEF_NUM_WAY,
  parameter int AFULL_LVL = DEPTH - NUM_WAY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_WAY-1:0]        in_vld,
  input  logic [NUM_WAY*DATA_W-1:0] in_data,
  output logic [NUM_WAY-1:0]        in_rdy,
  output logic [NUM_WAY-1:0]        out_vld,
  output logic [NUM_WAY*DATA_W-1:0] out_data,
  input  logic [NUM_WAY-1:0]        out_rdy,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      err_ovf,
  output logic                      err_udf,
  output logic                      err_gap
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t head_q, head_d, tail_q, tail_d;
  logic errOvf_q, errOvf_d, errUdf_q, errUdf_d, errGap_q, errGap_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  ptr_t      freeSlots, pushCnt, popCnt;
  lane_cnt_t pushLead, popLead;
  logic      pushGap, popGap;
  logic [NUM_WAY-1:0] wrEn;
  logic [AW-1:0]      wrIdx [NUM_WAY];
  logic [AW-1:0]      rdIdx [NUM_WAY];

  // The extra wrap bit lets a plain subtraction tell full from empty.
  assign count       = tail_q - head_q;
  assign freeSlots   = ptr_t'(DEPTH) - count;
  assign full        = (count == ptr_t'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= ptr_t'(AFULL_LVL));
  assign err_ovf     = errOvf_q;
  assign err_udf     = errUdf_q;
  assign err_gap     = errGap_q;

  mw_prefix_cnt #(.N(NUM_WAY)) uPushPrefix (
    .vec_i (in_vld),
    .cnt_o (pushLead),
    .gap_o (pushGap)
  );

  mw_prefix_cnt #(.N(NUM_WAY)) uPopPrefix (
    .vec_i (out_rdy),
    .cnt_o (popLead),
    .gap_o (popGap)
  );

  // Ready/valid are prefix masks, so the accepted run is the requested run clipped to space/occupancy.
  always_comb begin
    pushCnt = (ptr_t'(pushLead) <= freeSlots) ? ptr_t'(pushLead) : freeSlots;
    popCnt  = (ptr_t'(popLead) <= count) ? ptr_t'(popLead) : count;
    for (int i = 0; i < NUM_WAY; i++) begin
      in_rdy[i]  = freeSlots > ptr_t'(i);
      out_vld[i] = count > ptr_t'(i);
      wrEn[i]    = ptr_t'(i) < pushCnt;
      wrIdx[i]   = tail_q[AW-1:0] + AW'(i);
      rdIdx[i]   = head_q[AW-1:0] + AW'(i);
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (out_vld[i]) out_data[i*DATA_W +: DATA_W] = mem_q[rdIdx[i]];
    end
  end

  always_comb begin
    head_d   = head_q + popCnt;
    tail_d   = tail_q + pushCnt;
    errOvf_d = errOvf_q | (|(in_vld & ~in_rdy));
    errUdf_d = errUdf_q | (|(out_rdy & ~out_vld));
    errGap_d = errGap_q | pushGap | popGap;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      errOvf_d = 1'b0;
      errUdf_d = 1'b0;
      errGap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      errOvf_q <= 1'b0;
      errUdf_q <= 1'b0;
      errGap_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      errOvf_q <= errOvf_d;
      errUdf_q <= errUdf_d;
      errGap_q <= errGap_d;
    end
  end

  // Storage is never reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (wrEn[i]) mem_q[wrIdx[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mw_fifo.sv
// Self-checking bench for mw_fifo: a queue-based reference model compared every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_mw_fifo;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int NUM_WAY = 3;
  localparam int AFULL   = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_WAY-1:0]        in_vld, in_rdy, out_vld, out_rdy;
  logic [NUM_WAY*DATA_W-1:0] in_data, out_data;
  logic [3:0]                count;
  logic                      full, empty, almost_full, err_ovf, err_udf, err_gap;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  logic [7:0] modelQ[$];
  bit mOvf, mUdf, mGap;

  mw_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .NUM_WAY   (NUM_WAY),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_vld      (in_vld),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_rdy     (out_rdy),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf),
    .err_gap     (err_gap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the FIFO's behaviour from its rules, commit at the clock edge.
  task automatic applyStimulus(input logic [2:0] vld, input logic [23:0] data,
                               input logic [2:0] rdy, input logic fl);
    int sz, free, nPush, nPop;
    bit run, sawZero, gap, ovf, udf;
    in_vld = vld; in_data = data; out_rdy = rdy; flush = fl;
    sz = modelQ.size();
    free = DEPTH - sz;
    nPush = 0; nPop = 0; gap = 0; ovf = 0; udf = 0;
    run = 1;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (run && vld[i] && i < free) nPush++; else run = 0;
      if (vld[i] && i >= free) ovf = 1;
    end
    run = 1;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (run && rdy[i] && i < sz) nPop++; else run = 0;
      if (rdy[i] && i >= sz) udf = 1;
    end
    sawZero = 0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (!vld[i]) sawZero = 1; else if (sawZero) gap = 1;
    end
    sawZero = 0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (!rdy[i]) sawZero = 1; else if (sawZero) gap = 1;
    end
    @(posedge clk);
    if (fl) begin
      modelQ.delete();
      mOvf = 0; mUdf = 0; mGap = 0;
    end else begin
      repeat (nPop) void'(modelQ.pop_front());
      for (int i = 0; i < nPush; i++) modelQ.push_back(data[i*8 +: 8]);
      mOvf |= ovf; mUdf |= udf; mGap |= gap;
    end
    @(negedge clk);
    in_vld = '0; out_rdy = '0; flush = 1'b0;
  endtask

  // Every output depends only on registered state, so compare against the model mid-cycle.
  always @(negedge clk) begin
    int sz;
    logic [2:0]  expRdy, expVld;
    logic [23:0] expData;
    if (checkEn) begin
      sz = modelQ.size();
      expData = '0;
      for (int i = 0; i < NUM_WAY; i++) begin
        expRdy[i] = (i < DEPTH - sz);
        expVld[i] = (i < sz);
        if (i < sz) expData[i*8 +: 8] = modelQ[i];
      end
      checkOutput("model count", 32'(count), 32'(sz));
      checkOutput("model in_rdy", 32'(in_rdy), 32'(expRdy));
      checkOutput("model out_vld", 32'(out_vld), 32'(expVld));
      checkOutput("model out_data", 32'(out_data), 32'(expData));
      checkOutput("model full", 32'(full), 32'(sz == DEPTH));
      checkOutput("model empty", 32'(empty), 32'(sz == 0));
      checkOutput("model almost_full", 32'(almost_full), 32'(sz >= AFULL));
      checkOutput("model err_ovf", 32'(err_ovf), 32'(mOvf));
      checkOutput("model err_udf", 32'(err_udf), 32'(mUdf));
      checkOutput("model err_gap", 32'(err_gap), 32'(mGap));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = '0; out_rdy = '0; in_data = '0;
    mOvf = 0; mUdf = 0; mGap = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;
    #1;
    checkOutput("reset in_rdy", 32'(in_rdy), 32'h7);
    checkOutput("reset out_vld", 32'(out_vld), 32'h0);
    checkOutput("reset empty", 32'(empty), 32'h1);
    @(negedge clk);

    applyStimulus(3'b111, {8'd3, 8'd2, 8'd1}, 3'b000, 1'b0);
    checkOutput("first push count", 32'(count), 32'd3);
    checkOutput("first push out_vld", 32'(out_vld), 32'h7);
    checkOutput("first push out_data", 32'(out_data), 32'h030201);

    applyStimulus(3'b001, {8'd0, 8'd0, 8'd4}, 3'b000, 1'b0);
    applyStimulus(3'b111, {8'd7, 8'd6, 8'd5}, 3'b011, 1'b0);
    checkOutput("push3 pop2 count", 32'(count), 32'd5);
    checkOutput("push3 pop2 almost_full", 32'(almost_full), 32'h1);
    checkOutput("push3 pop2 out_data", 32'(out_data), 32'h050403);

    applyStimulus(3'b111, {8'd10, 8'd9, 8'd8}, 3'b111, 1'b0);
    checkOutput("wrap out_data", 32'(out_data), 32'h080706);
    applyStimulus(3'b000, 24'h0, 3'b111, 1'b0);
    checkOutput("wrap tail out_data", 32'(out_data), 32'h000a09);
    checkOutput("wrap tail out_vld", 32'(out_vld), 32'h3);

    applyStimulus(3'b101, {8'd13, 8'd12, 8'd11}, 3'b000, 1'b0);
    checkOutput("gap count", 32'(count), 32'd3);
    checkOutput("gap err_gap", 32'(err_gap), 32'h1);
    checkOutput("gap out_data", 32'(out_data), 32'h0b0a09);
    applyStimulus(3'b111, {8'd99, 8'd98, 8'd97}, 3'b111, 1'b1);
    checkOutput("flush count", 32'(count), 32'd0);
    checkOutput("flush err_gap", 32'(err_gap), 32'h0);

    applyStimulus(3'b111, {8'd22, 8'd21, 8'd20}, 3'b000, 1'b0);
    applyStimulus(3'b111, {8'd25, 8'd24, 8'd23}, 3'b000, 1'b0);
    applyStimulus(3'b001, {8'd0, 8'd0, 8'd26}, 3'b000, 1'b0);
    checkOutput("count7 in_rdy", 32'(in_rdy), 32'h1);
    applyStimulus(3'b111, {8'd29, 8'd28, 8'd27}, 3'b000, 1'b0);
    checkOutput("overflow count", 32'(count), 32'd8);
    checkOutput("overflow full", 32'(full), 32'h1);
    checkOutput("overflow err_ovf", 32'(err_ovf), 32'h1);
    checkOutput("overflow out_data", 32'(out_data), 32'h161514);

    applyStimulus(3'b000, 24'h0, 3'b111, 1'b0);
    applyStimulus(3'b000, 24'h0, 3'b111, 1'b0);
    applyStimulus(3'b000, 24'h0, 3'b011, 1'b0);
    applyStimulus(3'b000, 24'h0, 3'b001, 1'b0);
    checkOutput("underflow err_udf", 32'(err_udf), 32'h1);
    checkOutput("underflow count", 32'(count), 32'd0);
    checkOutput("sticky err_ovf", 32'(err_ovf), 32'h1);

    applyStimulus(3'b111, {8'd42, 8'd41, 8'd40}, 3'b000, 1'b0);
    in_vld = 3'b111; in_data = {8'd45, 8'd44, 8'd43}; out_rdy = 3'b011;
    #2;
    rst = 1'b1;
    modelQ.delete();
    mOvf = 0; mUdf = 0; mGap = 0;
    #1;
    checkOutput("async reset in_rdy", 32'(in_rdy), 32'h7);
    checkOutput("async reset out_vld", 32'(out_vld), 32'h0);
    checkOutput("async reset out_data", 32'(out_data), 32'h0);
    checkOutput("async reset count", 32'(count), 32'd0);
    checkOutput("async reset err_udf", 32'(err_udf), 32'h0);
    @(negedge clk);
    rst = 1'b0; in_vld = '0; out_rdy = '0;
    @(negedge clk);
    applyStimulus(3'b001, {8'd0, 8'd0, 8'd50}, 3'b000, 1'b0);
    checkOutput("post reset out_data", 32'(out_data), 32'h000032);
    checkOutput("post reset count", 32'(count), 32'd1);

    applyStimulus(3'b000, 24'h0, 3'b000, 1'b0);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
